ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Instruction-fetch stage wrapped around the 32-bit PC register.
//  - Reads the current PC (the register's q) and drives pc_next (the register's d).
//  - Issues fixed-latency instruction-memory reads.
//  - Buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode over valid/ready.
//  - Handles redirects (branch/jump) by flushing the queue and squashing the in-flight read.
// PARAMETERS
//  DEPTH    4  queue entries; power of 2, >=2
//  PTR_W    2  log2(DEPTH)
// PORTS
//  clk            in   1   rising-edge clock
//  reset_n        in   1   asynchronous, active-low reset
//  pc             in   32  current PC (q of PC register)
//  pc_next        out  32  next PC (d of PC register)
//  redirect_valid in   1   taken branch/jump this cycle
//  redirect_pc    in   32  redirect target; bits[1:0] ignored (forced 00)
//  imem_req       out  1   read request, address = imem_addr
//  imem_addr      out  32  word-aligned fetch address
//  imem_rvalid    in   1   read data valid; exactly 1 cycle after imem_req
//  imem_rdata     in   32  instruction word
//  out_valid      out  1   head entry valid to decode
//  out_ready      in   1   decode accepts head
//  out_instr      out  32  head instruction
//  out_pc         out  32  PC of head instruction
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - Queue empty; count=0; inflight=0; kill=0; state=FETCH.
//   - Outputs: imem_req=0, imem_addr=0, pc_next=0 (matches PC-register reset), out_valid=0, out_instr=0, out_pc=0.
//   - An imem_rvalid arriving after reset deasserts is ignored (inflight was cleared).
//  Reservation
//   - Issue only if count+inflight < DEPTH. Invariant: count+inflight <= DEPTH, so the queue never overflows.
//   - issue = !redirect_valid && state!=STALL && (count+inflight < DEPTH).
//   - issue=1: imem_req=1, imem_addr=pc, pc_next=pc+32'd4 (mod 2^32; 0xFFFFFFFC wraps to 0).
//   - issue=0: imem_req=0, pc_next=pc (PC holds).
//  Response
//   - inflight <= issue.
//   - On imem_rvalid with inflight=1 and kill=0: push {imem_rdata, PC of request}. The request PC is registered at issue.
//  Pop
//   - out_valid && out_ready pops the head.
//   - Push and pop in the same cycle: count unchanged, head advances.
//  Redirect (highest priority)
//   - pc_next = {redirect_pc[31:2], 2'b00}; imem_req=0.
//   - out_valid is forced 0 that cycle, so no handshake occurs.
//   - Next edge: queue cleared (count=0, pointers 0); kill <= inflight.
//   - Redirect in consecutive cycles: the last target wins.
//  FSM (2-bit)
//   - FETCH: normal issue. -> STALL when count+inflight reaches DEPTH. -> FLUSH on redirect.
//   - STALL: no issue. -> FETCH when a pop frees a slot. -> FLUSH on redirect.
//   - FLUSH: one cycle; discards a killed response, clears kill; issue allowed at new pc. -> FETCH.
//  Latency (no bypass)
//   - imem_req -> imem_rvalid: 1 cycle.
//   - imem_rvalid -> out_valid: 1 cycle.
//   - Steady-state throughput: 1 instruction per cycle with out_ready=1.
// CONFIGURATION
//  IFQ_BYPASS_EN defined
//   - When count==0 and a valid unkilled response arrives: out_valid=1 that cycle, out_instr=imem_rdata, out_pc=request PC.
//   - If out_ready=1 the entry is not written; otherwise it is pushed.
//   - Redirect still forces out_valid=0.
//  IFQ_BYPASS_EN undefined
//   - out_valid is purely registered (count!=0); 1-cycle added latency.
// STRUCTURE
//  mips_defs.vh (shared include)
//   - `define WORD_W 32, `define PC_INC 32'd4, `define RESET_PC 32'h0.
//   - FSM state encodings IFQ_FETCH=2'd0, IFQ_STALL=2'd1, IFQ_FLUSH=2'd2.
//  Sub-module ifq_fifo (DEPTH x 64-bit {pc,instr})
//   - push, pop, clear, count, head out.
//   - Async active-low reset; wrap-around pointers of PTR_W bits.
//  Top level: issue logic, FSM, inflight/kill flags, pc_next mux.
// TESTING
//  1 Reset, out_ready=1, 1-cycle imem model
//    -> imem_addr 0,4,8,... on consecutive cycles.
//    -> out_pc 0 two cycles after first req (one cycle with IFQ_BYPASS_EN).
//  2 out_ready=0 from start
//    -> exactly 4 requests (addr 0..0xC), then imem_req=0 and pc_next==pc.
//    -> Raise out_ready: entries pop in order 0,4,8,C; fetch resumes at 0x10.
//  3 redirect_valid=1, redirect_pc=0x107 while one read in flight
//    -> pc_next=0x104; in-flight response dropped; queue empty.
//    -> Next out_pc=0x104.
//  4 pc=0xFFFFFFFC, issue -> pc_next=0; following fetch at address 0.
//  5 Full queue, simultaneous pop and response -> count stays DEPTH-1+1; no overflow; order preserved.
//  6 reset_n pulsed low mid-stream with a read in flight
//    -> all outputs 0 immediately; stale imem_rvalid ignored; fetch restarts at 0.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Optional combinational bypass is selected by IFQ_BYPASS_EN.
package ifetch_queue_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    IFQ_FETCH = 2'd0,
    IFQ_STALL = 2'd1,
    IFQ_FLUSH = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// DEPTH-entry {pc,instr} queue with wrap-around pointers.
// Clear has priority over push/pop.
module ifetch_queue_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  ifq_entry_t       din,
  output ifq_entry_t       head,
  output logic [PTR_W:0]   count
);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: PC advance, 1-cycle imem reads, queue to decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_next,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc
);

  localparam logic [PTR_W+1:0] FULL = (PTR_W+2)'(DEPTH);

  ifq_state_e        state;
  ifq_state_e        state_nx;
  logic              inflight;
  logic              kill;
  logic [WORD_W-1:0] req_pc;
  logic [PTR_W:0]    count;
  ifq_entry_t        head;
  ifq_entry_t        din;
  logic              issue;
  logic              resp_ok;
  logic              byp;
  logic              push;
  logic              pop;
  logic [PTR_W+1:0]  occ;
  logic [PTR_W+1:0]  occ_nx;

  assign occ     = (PTR_W+2)'(count) + (PTR_W+2)'(inflight);
  assign resp_ok = imem_rvalid && inflight && !kill;
  assign issue   = reset_n && !redirect_valid
                && (state != IFQ_STALL) && (occ < FULL);

`ifdef IFQ_BYPASS_EN
  assign byp = resp_ok && (count == '0) && !redirect_valid;
`else
  assign byp = 1'b0;
`endif

  assign din  = '{pc: req_pc, instr: imem_rdata};
  assign push = resp_ok && !(byp && out_ready);
  assign pop  = out_valid && out_ready && !byp;

  always_comb begin
    out_valid = 1'b0;
    out_instr = head.instr;
    out_pc    = head.pc;
    if (!redirect_valid) begin
      out_valid = (count != '0) || byp;
    end
    if (byp) begin
      out_instr = imem_rdata;
      out_pc    = req_pc;
    end
  end

  always_comb begin
    pc_next   = pc;
    imem_req  = issue;
    imem_addr = '0;
    if (!reset_n) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = {redirect_pc[WORD_W-1:2], 2'b00};
    end else if (issue) begin
      pc_next   = pc + PC_INC;
      imem_addr = pc;
    end
  end

  // Occupancy after this edge, counting the read issued now
  assign occ_nx = (PTR_W+2)'(count) + (PTR_W+2)'(push)
                + (PTR_W+2)'(issue) - (PTR_W+2)'(pop);

  always_comb begin
    state_nx = state;
    unique case (state)
      IFQ_FETCH, IFQ_FLUSH: begin
        if (redirect_valid)      state_nx = IFQ_FLUSH;
        else if (occ_nx >= FULL) state_nx = IFQ_STALL;
        else                     state_nx = IFQ_FETCH;
      end
      IFQ_STALL: begin
        if (redirect_valid)     state_nx = IFQ_FLUSH;
        else if (occ_nx < FULL) state_nx = IFQ_FETCH;
      end
      default: state_nx = IFQ_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IFQ_FETCH;
      inflight <= 1'b0;
      kill     <= 1'b0;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (redirect_valid)        kill <= inflight;
      else if (state == IFQ_FLUSH) kill <= 1'b0;
      if (issue) req_pc <= pc;
    end
  end

  ifetch_queue_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .clear   (redirect_valid),
    .din     (din),
    .head    (head),
    .count   (count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue with a PC register and
// a 1-cycle instruction memory model.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          n_chk;
  int          n_fail;
  int          hs;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc             (pc),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= 32'h0;
    else          pc <= pc_next;
  end

  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= ins(imem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset(input logic rdy);
    reset_n        = 1'b0;
    out_ready      = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    step();
    sb.delete();
    hs      = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    bit found;
    n_chk          = 0;
    n_fail         = 0;
    hs             = 0;
    reset_n        = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 reset_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (reset_n && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL mon_extra: got pc %h want none", out_pc);
          end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("mon_pc", out_pc, e);
            chk("mon_instr", out_instr, ins(e));
          end
          hs++;
        end
      end
    join_none

    // 1: streaming fetch, out_ready high
    do_reset(1'b1);
    expect_seq(32'h0, 40);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k < 8) begin
        chk("t1_req", {31'b0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr, 32'(4 * k));
      end
      if (k == 0) chk("t1_lat0", {31'b0, out_valid}, 32'h0);
      if (k == 1) chk("t1_lat1", {31'b0, out_valid}, {31'b0, BYP});
      if (k == 2) chk("t1_lat2", {31'b0, out_valid}, 32'h1);
      step();
    end
    #1;
    chk("t1_pops", 32'(hs), BYP ? 32'd11 : 32'd10);

    // 2: out_ready low fills the queue, then drains in order
    do_reset(1'b0);
    expect_seq(32'h0, 40);
    for (int k = 0; k < 7; k++) begin
      #1;
      if (k < 4) begin
        chk("t2_req", {31'b0, imem_req}, 32'h1);
        chk("t2_addr", imem_addr, 32'(4 * k));
      end else begin
        chk("t2_stall_req", {31'b0, imem_req}, 32'h0);
        chk("t2_hold", pc_next, 32'h10);
      end
      step();
    end
    out_ready = 1'b1;
    found     = 1'b0;
    for (int w = 0; w < 6; w++) begin
      #1;
      if (imem_req) begin
        chk("t2_resume", imem_addr, 32'h10);
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) chk("t2_resume_timeout", 32'h0, 32'h1);
    for (int k = 0; k < 8; k++) step();
    chk("t2_pops", {31'b0, hs >= 5}, 32'h1);

    // 3: redirect squashes the in-flight read
    do_reset(1'b1);
    #1;
    chk("t3_addr0", imem_addr, 32'h0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h107;
    expect_seq(32'h104, 30);
    #1;
    chk("t3_pc_next", pc_next, 32'h104);
    chk("t3_req", {31'b0, imem_req}, 32'h0);
    chk("t3_ovalid", {31'b0, out_valid}, 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_addr", imem_addr, 32'h104);
    chk("t3_empty", {31'b0, out_valid}, 32'h0);
    for (int k = 0; k < 6; k++) step();
    chk("t3_pops", {31'b0, hs >= 3}, 32'h1);

    // 3b: back-to-back redirects, last one wins
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    chk("t3b_pc_next0", pc_next, 32'h300);
    chk("t3b_req", {31'b0, imem_req}, 32'h0);
    step();
    redirect_pc = 32'h402;
    #1;
    chk("t3b_pc_next1", pc_next, 32'h400);
    step();
    redirect_valid = 1'b0;
    expect_seq(32'h400, 30);
    #1;
    chk("t3b_addr", imem_addr, 32'h400);
    for (int k = 0; k < 6; k++) step();
    chk("t3b_pops", {31'b0, hs >= 3}, 32'h1);

    // 4: PC wrap at top of address space
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    #1;
    chk("t4_align", pc_next, 32'hFFFF_FFFC);
    step();
    redirect_valid = 1'b0;
    sb.push_back(32'hFFFF_FFFC);
    expect_seq(32'h0, 30);
    #1;
    chk("t4_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t4_wrap", pc_next, 32'h0);
    step();
    #1;
    chk("t4_addr0", imem_addr, 32'h0);
    for (int k = 0; k < 6; k++) step();
    chk("t4_pops", {31'b0, hs >= 3}, 32'h1);

    // 5: full occupancy, pop and response in the same cycle
    do_reset(1'b0);
    expect_seq(32'h0, 40);
    for (int k = 0; k < 4; k++) step();
    out_ready = 1'b1;
    #1;
    chk("t5_valid", {31'b0, out_valid}, 32'h1);
    chk("t5_head", out_pc, 32'h0);
    chk("t5_req", {31'b0, imem_req}, 32'h0);
    step();
    #1;
    chk("t5_resume", imem_addr, 32'h10);
    for (int k = 0; k < 8; k++) step();
    chk("t5_pops", {31'b0, hs >= 6}, 32'h1);

    // 6: reset pulse with a response in flight
    do_reset(1'b1);
    expect_seq(32'h0, 40);
    for (int k = 0; k < 4; k++) step();
    #1;
    sb.delete();
    reset_n = 1'b0;
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'h0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_pc_next", pc_next, 32'h0);
    chk("t6_ovalid", {31'b0, out_valid}, 32'h0);
    chk("t6_oinstr", out_instr, 32'h0);
    chk("t6_opc", out_pc, 32'h0);
    reset_n = 1'b1;
    hs      = 0;
    expect_seq(32'h0, 30);
    #1;
    chk("t6_stale", {31'b0, out_valid}, 32'h0);
    chk("t6_refetch", imem_addr, 32'h0);
    for (int k = 0; k < 8; k++) step();
    chk("t6_pops", {31'b0, hs >= 5}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
